// File: rtl/top_core.sv
// ---------------------------------------------------------------------------
// top_core
//   Register-access core driven by a single-lane SPI slave (mode 0).
//   All SPI pins are synchronised into the clk_i domain and sclk edges are
//   detected there. The host must hold sclk high and low for at least 4
//   clk_i cycles each.
//
//   Frame: cs low, 8 command bits then 32 data bits, MSB first, sampled
//   on sclk rising edges.
//     0x01 write reg0 (gpio)   0x05 read reg0
//     0x07 read reg1 (ID)      0x11 write reg2 (scratch)
//     0x15 read reg2           0x17 read reg3 = {30'b0, en_ifetch, fetch_enable}
//   Other command values are ignored until cs rises.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous reset, active-high
//   fetch_enable_i status input, reg3 bit0
//   en_ifetch_i    status input, reg3 bit1
//   spi_sclk       SPI clock
//   spi_cs         chip select, active-low
//   spi_sdi0..3    serial data in (only sdi0 is used)
//   spi_mode       always 2'b00 (single lane)
//   spi_sdo0       serial read data
//   spi_sdo1..3    always 0
//   gpio_o         contents of reg0
// ---------------------------------------------------------------------------
module top_core #(
    parameter logic [31:0] ID_VALUE   = 32'h0000_0020,
    parameter logic [31:0] GPIO_RESET = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    input  logic        en_ifetch_i,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic [1:0]  spi_mode,
    output logic        spi_sdo0,
    output logic        spi_sdo1,
    output logic        spi_sdo2,
    output logic        spi_sdo3,
    output logic [31:0] gpio_o
);

    localparam int DATA_W = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [7:0] CMD_WR_REG0 = 8'h01;
    localparam logic [7:0] CMD_RD_REG0 = 8'h05;
    localparam logic [7:0] CMD_RD_REG1 = 8'h07;
    localparam logic [7:0] CMD_WR_REG2 = 8'h11;
    localparam logic [7:0] CMD_RD_REG2 = 8'h15;
    localparam logic [7:0] CMD_RD_REG3 = 8'h17;

    // Synchroniser stages; sclk_p2 is the edge-detect history bit.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1;
    logic sdi_p0, sdi_p1;
    logic fe_p0, fe_p1;
    logic ei_p0, ei_p1;

    logic [2:0]        state;
    logic [5:0]        bit_cnt;
    logic [7:0]        cmd_sr;
    logic [DATA_W-2:0] wr_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] reg0;
    logic [DATA_W-1:0] reg2;

    logic              sclk_rise;
    logic              sclk_fall;
    logic [7:0]        cmd_next;
    logic [DATA_W-1:0] wr_next;
    logic [DATA_W-1:0] reg3;
    logic              unused_sdi;

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign cmd_next  = {cmd_sr[6:0], sdi_p1};
    assign wr_next   = {wr_sr, sdi_p1};
    assign reg3      = {30'b0, ei_p1, fe_p1};

    assign unused_sdi = ^{spi_sdi1, spi_sdi2, spi_sdi3};

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            sdi_p0  <= 1'b0;
            sdi_p1  <= 1'b0;
            fe_p0   <= 1'b0;
            fe_p1   <= 1'b0;
            ei_p0   <= 1'b0;
            ei_p1   <= 1'b0;
            state   <= ST_IDLE;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            wr_sr   <= '0;
            tx_sr   <= '0;
            reg0    <= GPIO_RESET;
            reg2    <= '0;
        end else begin
            // Stage p0 -> p1 -> p2: pin synchronisation and sclk history
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi_cs;
            cs_p1   <= cs_p0;
            sdi_p0  <= spi_sdi0;
            sdi_p1  <= sdi_p0;
            fe_p0   <= fetch_enable_i;
            fe_p1   <= fe_p0;
            ei_p0   <= en_ifetch_i;
            ei_p1   <= ei_p0;

            // Frame control on synchronised samples
            if (cs_p1) begin
                // cs high aborts any frame; a pending write is simply dropped
                state   <= ST_IDLE;
                bit_cnt <= '0;
                tx_sr   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        cmd_sr  <= '0;
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) begin
                                case (cmd_next)
                                    CMD_WR_REG0, CMD_WR_REG2: state <= ST_WRITE;
                                    CMD_RD_REG0: begin tx_sr <= reg0;     state <= ST_READ; end
                                    CMD_RD_REG1: begin tx_sr <= ID_VALUE; state <= ST_READ; end
                                    CMD_RD_REG2: begin tx_sr <= reg2;     state <= ST_READ; end
                                    CMD_RD_REG3: begin tx_sr <= reg3;     state <= ST_READ; end
                                    default:     state <= ST_IGNORE;
                                endcase
                            end
                        end
                    end
                    ST_READ: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd39) begin
                                state <= ST_DONE;
                                tx_sr <= '0;
                            end
                        end else if (sclk_fall && bit_cnt >= 6'd9) begin
                            // The fall right after the load is skipped so bit31
                            // stays on sdo0 until the host samples it.
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                    end
                    ST_WRITE: begin
                        if (sclk_rise) begin
                            wr_sr   <= wr_next[DATA_W-2:0];
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd39) begin
                                state <= ST_DONE;
                                if (cmd_sr == CMD_WR_REG0) reg0 <= wr_next;
                                else                       reg2 <= wr_next;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd39) state <= ST_DONE;
                        end
                    end
                    default: begin
                        // DONE: extra sclk edges are ignored until cs rises
                        state <= ST_DONE;
                    end
                endcase
            end
        end
    end

    assign spi_sdo0 = (state == ST_READ) ? tx_sr[DATA_W-1] : 1'b0;
    assign spi_sdo1 = 1'b0;
    assign spi_sdo2 = 1'b0;
    assign spi_sdo3 = 1'b0;
    assign spi_mode = 2'b00;
    assign gpio_o   = reg0;

endmodule

// File: tb/tb_top_core.sv
// ---------------------------------------------------------------------------
// tb_top_core
//   Directed SPI frames against top_core with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_top_core;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        fetch_enable_i = 1'b0;
    logic        en_ifetch_i = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sdi0 = 1'b0;
    logic        spi_sdi1 = 1'b0;
    logic        spi_sdi2 = 1'b0;
    logic        spi_sdi3 = 1'b0;
    logic [1:0]  spi_mode;
    logic        spi_sdo0;
    logic        spi_sdo1;
    logic        spi_sdo2;
    logic        spi_sdo3;
    logic [31:0] gpio_o;

    int n_cmp = 0;
    int n_err = 0;

    top_core dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .fetch_enable_i (fetch_enable_i),
        .en_ifetch_i    (en_ifetch_i),
        .spi_sclk       (spi_sclk),
        .spi_cs         (spi_cs),
        .spi_sdi0       (spi_sdi0),
        .spi_sdi1       (spi_sdi1),
        .spi_sdi2       (spi_sdi2),
        .spi_sdi3       (spi_sdi3),
        .spi_mode       (spi_mode),
        .spi_sdo0       (spi_sdo0),
        .spi_sdo1       (spi_sdo1),
        .spi_sdo2       (spi_sdo2),
        .spi_sdo3       (spi_sdo3),
        .gpio_o         (gpio_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One SPI bit: present data, sample sdo0 just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        spi_sdi0 = b;
        wait_clk(5);
        r = spi_sdo0;
        spi_sclk = 1'b1;
        wait_clk(5);
        spi_sclk = 1'b0;
    endtask

    // Full or truncated frame: 8 command bits then n_data data bits.
    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] wdata,
                             input int n_data, output logic [31:0] rdata,
                             output logic sdo_any);
        logic r;
        rdata   = '0;
        sdo_any = 1'b0;
        spi_cs  = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 8 + n_data; i++) begin
            if (i < 8) spi_bit(cmd[7-i], r);
            else       spi_bit(wdata[39-i], r);
            if (i >= 8) rdata[39-i] = r;
            sdo_any = sdo_any | r;
        end
        wait_clk(5);
        spi_cs = 1'b1;
        wait_clk(10);
    endtask

    logic [31:0] rd;
    logic        any;
    logic        rb;

    initial begin
        wait_clk(4);
        rst_ni = 1'b0;
        wait_clk(4);

        check_eq("rst_gpio", gpio_o, 32'h0000_0000);
        check_eq("rst_sdo0", {31'b0, spi_sdo0}, 32'h0);
        check_eq("spi_mode", {30'b0, spi_mode}, 32'h0);
        check_eq("sdo123", {29'b0, spi_sdo1, spi_sdo2, spi_sdo3}, 32'h0);

        spi_frame(8'h07, 32'h0, 32, rd, any);
        check_eq("id_read", rd, 32'h0000_0020);

        spi_frame(8'h01, 32'hA5A5_1234, 32, rd, any);
        check_eq("wr_gpio", gpio_o, 32'hA5A5_1234);
        spi_frame(8'h05, 32'h0, 32, rd, any);
        check_eq("rd_reg0", rd, 32'hA5A5_1234);

        spi_frame(8'h11, 32'hDEAD_BEEF, 32, rd, any);
        spi_frame(8'h15, 32'h0, 32, rd, any);
        check_eq("rd_reg2", rd, 32'hDEAD_BEEF);
        spi_frame(8'h07, 32'h0, 32, rd, any);
        check_eq("id_again", rd, 32'h0000_0020);
        check_eq("gpio_kept", gpio_o, 32'hA5A5_1234);

        fetch_enable_i = 1'b1;
        en_ifetch_i    = 1'b0;
        wait_clk(4);
        spi_frame(8'h17, 32'h0, 32, rd, any);
        check_eq("reg3_fe", rd, 32'h0000_0001);
        fetch_enable_i = 1'b0;
        en_ifetch_i    = 1'b1;
        wait_clk(4);
        spi_frame(8'h17, 32'h0, 32, rd, any);
        check_eq("reg3_ei", rd, 32'h0000_0002);

        // Truncated write: cs rises after 20 data bits
        spi_frame(8'h01, 32'h1357_9BDF, 20, rd, any);
        check_eq("abort_gpio", gpio_o, 32'hA5A5_1234);

        // Unknown command with all-ones data
        spi_frame(8'h3C, 32'hFFFF_FFFF, 32, rd, any);
        check_eq("unk_sdo", {31'b0, any}, 32'h0);
        check_eq("unk_gpio", gpio_o, 32'hA5A5_1234);
        spi_frame(8'h15, 32'h0, 32, rd, any);
        check_eq("unk_reg2", rd, 32'hDEAD_BEEF);

        // Reset in the middle of a reg0 read: 10 data bits out (bits 31..22),
        // sdo0 now shows bit21 of 0xA5A51234, which is 1.
        spi_cs = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 18; i++) begin
            if (i < 8) spi_bit(((8'h05 >> (7 - i)) & 8'h01) != 8'h00, rb);
            else       spi_bit(1'b0, rb);
        end
        wait_clk(5);
        check_eq("pre_rst_sdo", {31'b0, spi_sdo0}, 32'h1);
        rst_ni = 1'b1;
        #1;
        check_eq("mid_rst_sdo", {31'b0, spi_sdo0}, 32'h0);
        check_eq("mid_rst_gpio", gpio_o, 32'h0000_0000);
        spi_cs = 1'b1;
        wait_clk(3);
        rst_ni = 1'b0;
        wait_clk(4);

        spi_frame(8'h07, 32'h0, 32, rd, any);
        check_eq("post_rst_id", rd, 32'h0000_0020);
        spi_frame(8'h05, 32'h0, 32, rd, any);
        check_eq("post_rst_reg0", rd, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/top_core.md
Name: top_core

Overview:
- Register-access core controlled over SPI; an external host reads and writes a small register bank through a single-lane SPI slave.
- Register 0 drives the GPIO outputs. Register 1 is a read-only ID register whose value is 32.
- Everything runs on one system clock: the SPI pins are synchronized and edge-detected in the clk_i domain, so the block sits at the top of the test chip behind the SPI pads.

Parameters:
- ID_VALUE, 32'h0000_0020, read-only contents of register 1.
- GPIO_RESET, 32'h0000_0000, reset value of register 0 / gpio_o.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous reset, active-high: rst_ni=1 resets the block. The codebase name is kept; the polarity is fixed as stated.
- fetch_enable_i  in  1  status input, readable via register 3 bit0.
- en_ifetch_i  in  1  status input, readable via register 3 bit1.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_cs  in  1  chip select, active-low.
- spi_sdi0..spi_sdi3  in  1 each  serial data in; only sdi0 is used, sdi1..3 are ignored.
- spi_mode  out  2  constant 2'b00 (single-lane mode).
- spi_sdo0  out  1  serial read data.
- spi_sdo1..spi_sdo3  out  1 each  constant 0.
- gpio_o  out  32  mirrors register 0.

Behaviour:
- Synchronization:
  - spi_sclk, spi_cs and spi_sdi0 each pass through 2-flop synchronizers.
  - Rising and falling sclk edges are detected from the synchronized samples.
  - Host constraint: sclk high time and low time each ≥4 clk_i cycles.
- Reset:
  - State machine goes to IDLE; bit counter = 0; shift registers = 0; spi_sdo0 = 0.
  - reg0 = GPIO_RESET, so gpio_o = GPIO_RESET; reg2 = 0.
- Frame structure:
  - A frame starts when synchronized cs goes low; cs high at any time forces IDLE.
  - sdi0 is sampled on sclk rising edges, MSB first.
  - Bits 1–8 are the command byte.
  - Bits 9–40 are 32 data bits: sampled from sdi0 for writes, driven on sdo0 for reads.
- Command map (other values: the frame is ignored, sdo0 stays 0, no register changes until cs rises):
  - 0x01: write reg0.
  - 0x05: read reg0.
  - 0x07: read reg1 (ID_VALUE).
  - 0x11: write reg2 (scratch).
  - 0x15: read reg2.
  - 0x17: read reg3 = {30'b0, en_ifetch_i, fetch_enable_i}, both bits synchronized.
  - Writes to reg1 and reg3 do not exist.
- State machine:
  - IDLE → CMD on cs falling.
  - CMD → READ or WRITE after the 8th rising edge (unknown command → IGNORE).
  - READ, WRITE or IGNORE → DONE after the 40th rising edge.
  - DONE → IDLE on cs high.
  - Any state → IDLE on cs high.
- Read timing:
  - On the 8th rising edge the selected 32-bit value is loaded into the output shift register, and sdo0 immediately presents bit31 (no dummy cycles).
  - On each subsequent sclk falling edge the register shifts left, so bit[31-k] is valid before rising edge 9+k.
  - After bit0 has been sampled, and in IDLE, sdo0 = 0.
  - The value is captured at the load point; later input changes do not affect the frame in flight.
- Write timing:
  - The target register updates exactly once, 1–2 clk_i cycles after the synchronized 40th rising edge.
  - gpio_o follows reg0 directly.
  - If cs rises before bit 40, the write is discarded and the register keeps its old value.
- Extra sclk edges after bit 40 within the same frame are ignored.
- Reset asserted mid-frame aborts the frame immediately, and register values return to their reset values.

Test Plan:
- Reset, then frame cmd 0x07 + 32 read clocks → rd_data = 32 (0x0000_0020); sdo1..3 = 0; spi_mode = 00.
- Write 0xA5A5_1234 with cmd 0x01 → gpio_o = 0xA5A5_1234 after the frame; then cmd 0x05 reads back 0xA5A5_1234.
- Write 0xDEAD_BEEF with cmd 0x11, then cmd 0x15 → 0xDEAD_BEEF; then cmd 0x07 still → 32.
- Drive fetch_enable_i=1, en_ifetch_i=0, then cmd 0x17 → 0x0000_0001; swap the two inputs → 0x0000_0002.
- Cmd 0x01 with cs raised after 20 data bits → gpio_o unchanged; unknown cmd 0x3C followed by 32 clocks → sdo0 held 0, no register changes.
- Assert rst_ni=1 mid-read of reg0 → sdo0 = 0, gpio_o = 0; after release, cmd 0x07 → 32.
